l2_port_arbiter: RTL and testbench

- Shares the single L2 cache port between the instruction L1 cache (read-only) and the data L1 cache (read/write).
- Registered-grant FSM: one requester owns the L2 port from grant until L2 resp.
- L2 resp is routed back only to the owner.
- Fixed data-side priority, plus a starvation limit that guarantees instruction fetch progress.

---
 rtl/l2_port_arbiter_pkg.sv | 15 +
 rtl/l2_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_l2_port_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_port_arbiter_pkg.sv
// Shared LC-3b memory types plus the L2 port arbiter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } l2arb_state_t;

  localparam int L2ARB_STARVE_W = 4;

endpackage

// File: rtl/l2_port_arbiter.sv
// Arbitrates the single L2 port between icache (read-only) and dcache (read/write).
// ARB_ROUND_ROBIN_EN swaps fixed dcache priority + starvation limit for alternating grants.
//
// state   | meaning
// IDLE    | no owner; arbitrate between pending requests
// SERVE_I | icache owns the L2 port until l2arb_mem_resp
// SERVE_D | dcache owns the L2 port until l2arb_mem_resp
module l2_port_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,

  input  lc3b_word       i_arb_mem_address,
  input  logic           i_arb_mem_read,
  output lc3b_cache_line i_arb_mem_rdata,
  output logic           i_arb_mem_resp,

  input  lc3b_word       d_arb_mem_address,
  input  logic           d_arb_mem_read,
  input  logic           d_arb_mem_write,
  input  lc3b_cache_line d_arb_mem_wdata,
  output lc3b_cache_line d_arb_mem_rdata,
  output logic           d_arb_mem_resp,

  output lc3b_word       l2arb_mem_address,
  output logic           l2arb_mem_read,
  output logic           l2arb_mem_write,
  output lc3b_cache_line l2arb_mem_wdata,
  input  lc3b_cache_line l2arb_mem_rdata,
  input  logic           l2arb_mem_resp
);

  l2arb_state_t state_q, state_d;
  logic         i_req, d_req, grant_i;

  assign i_req = i_arb_mem_read;
  assign d_req = d_arb_mem_read | d_arb_mem_write;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant: 0 = icache, 1 = dcache; on contention the other side wins.
  logic last_grant_q, last_grant_d;

  assign grant_i = i_req & (~d_req | last_grant_q);

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && (i_req || d_req)) begin
      last_grant_d = ~grant_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  localparam logic [L2ARB_STARVE_W-1:0] LIMIT = L2ARB_STARVE_W'(STARVE_LIMIT);

  logic [L2ARB_STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  assign grant_i = i_req & (~d_req | (starve_cnt_q >= LIMIT));

  // Counts dcache wins taken over a waiting icache request.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == IDLE) begin
      if (grant_i) begin
        starve_cnt_d = '0;
      end else if (d_req && i_req && (starve_cnt_q != '1)) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d = SERVE_I;
        end else if (d_req) begin
          state_d = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2arb_mem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_arb_mem_rdata = l2arb_mem_rdata;
  assign d_arb_mem_rdata = l2arb_mem_rdata;

  always_comb begin
    l2arb_mem_address = '0;
    l2arb_mem_read    = 1'b0;
    l2arb_mem_write   = 1'b0;
    l2arb_mem_wdata   = '0;
    i_arb_mem_resp    = 1'b0;
    d_arb_mem_resp    = 1'b0;
    unique case (state_q)
      SERVE_I: begin
        l2arb_mem_address = i_arb_mem_address;
        l2arb_mem_read    = 1'b1;
        i_arb_mem_resp    = l2arb_mem_resp;
      end
      SERVE_D: begin
        // A simultaneous read+write is illegal; the write is kept.
        l2arb_mem_address = d_arb_mem_address;
        l2arb_mem_read    = d_arb_mem_read & ~d_arb_mem_write;
        l2arb_mem_write   = d_arb_mem_write;
        l2arb_mem_wdata   = d_arb_mem_wdata;
        d_arb_mem_resp    = l2arb_mem_resp;
      end
      default: ;
    endcase
  end

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    (state_q == SERVE_D) |-> !(d_arb_mem_read && d_arb_mem_write));

  a_i_req_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == SERVE_I) |-> i_arb_mem_read);

  a_d_req_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == SERVE_D) |-> (d_arb_mem_read || d_arb_mem_write));

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed self-checking bench for l2_port_arbiter (build with ARB_ROUND_ROBIN_EN for the alternate grant order).
module tb_l2_port_arbiter;
  import lc3b_types::*;

  logic           clk = 1'b0;
  logic           rst;
  lc3b_word       i_arb_mem_address;
  logic           i_arb_mem_read;
  lc3b_cache_line i_arb_mem_rdata;
  logic           i_arb_mem_resp;
  lc3b_word       d_arb_mem_address;
  logic           d_arb_mem_read;
  logic           d_arb_mem_write;
  lc3b_cache_line d_arb_mem_wdata;
  lc3b_cache_line d_arb_mem_rdata;
  logic           d_arb_mem_resp;
  lc3b_word       l2arb_mem_address;
  logic           l2arb_mem_read;
  logic           l2arb_mem_write;
  lc3b_cache_line l2arb_mem_wdata;
  lc3b_cache_line l2arb_mem_rdata;
  logic           l2arb_mem_resp;

  int checks   = 0;
  int failures = 0;

  localparam lc3b_cache_line RDATA = 128'hDEADBEEF_00112233_44556677_DEADBEEF;
  localparam lc3b_cache_line WDATA = 128'h01234567_89ABCDEF_01234567_89ABCDEF;

  always #5 clk = ~clk;

  l2_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_arb_mem_address (i_arb_mem_address),
    .i_arb_mem_read    (i_arb_mem_read),
    .i_arb_mem_rdata   (i_arb_mem_rdata),
    .i_arb_mem_resp    (i_arb_mem_resp),
    .d_arb_mem_address (d_arb_mem_address),
    .d_arb_mem_read    (d_arb_mem_read),
    .d_arb_mem_write   (d_arb_mem_write),
    .d_arb_mem_wdata   (d_arb_mem_wdata),
    .d_arb_mem_rdata   (d_arb_mem_rdata),
    .d_arb_mem_resp    (d_arb_mem_resp),
    .l2arb_mem_address (l2arb_mem_address),
    .l2arb_mem_read    (l2arb_mem_read),
    .l2arb_mem_write   (l2arb_mem_write),
    .l2arb_mem_wdata   (l2arb_mem_wdata),
    .l2arb_mem_rdata   (l2arb_mem_rdata),
    .l2arb_mem_resp    (l2arb_mem_resp)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rd"},   128'(l2arb_mem_read),    128'd0);
    chk({tag, "_wr"},   128'(l2arb_mem_write),   128'd0);
    chk({tag, "_addr"}, 128'(l2arb_mem_address), 128'd0);
    chk({tag, "_wd"},   l2arb_mem_wdata,         128'd0);
    chk({tag, "_iresp"}, 128'(i_arb_mem_resp),   128'd0);
    chk({tag, "_dresp"}, 128'(d_arb_mem_resp),   128'd0);
  endtask

  logic exp_i [10];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_i = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    rst               = 1'b1;
    i_arb_mem_address = 16'h0040;
    i_arb_mem_read    = 1'b1;
    d_arb_mem_address = 16'h1230;
    d_arb_mem_read    = 1'b1;
    d_arb_mem_write   = 1'b0;
    d_arb_mem_wdata   = '0;
    l2arb_mem_rdata   = '0;
    l2arb_mem_resp    = 1'b0;

    // Reset with both requests pending, then dcache wins first.
    cyc(); cyc();
    chk_idle("rst");
    rst = 1'b0;
    cyc();
    chk("rel_rd",   128'(l2arb_mem_read),    128'd1);
    chk("rel_wr",   128'(l2arb_mem_write),   128'd0);
    chk("rel_addr", 128'(l2arb_mem_address), 128'h1230);
    l2arb_mem_resp = 1'b1;
    settle();
    chk("rel_dresp", 128'(d_arb_mem_resp), 128'd1);
    chk("rel_iresp", 128'(i_arb_mem_resp), 128'd0);
    cyc();
    l2arb_mem_resp = 1'b0;
    d_arb_mem_read = 1'b0;
    i_arb_mem_read = 1'b0;
    settle();
    chk_idle("rel_gap");
    cyc();

    // Lone icache read with a 5-cycle L2 latency.
    i_arb_mem_read = 1'b1;
    cyc();
    chk("i_rd",   128'(l2arb_mem_read),    128'd1);
    chk("i_addr", 128'(l2arb_mem_address), 128'h0040);
    repeat (4) cyc();
    chk("i_addr_hold", 128'(l2arb_mem_address), 128'h0040);
    l2arb_mem_rdata = RDATA;
    l2arb_mem_resp  = 1'b1;
    settle();
    chk("i_resp",  128'(i_arb_mem_resp), 128'd1);
    chk("i_dresp", 128'(d_arb_mem_resp), 128'd0);
    chk("i_rdata", i_arb_mem_rdata, RDATA);
    cyc();
    l2arb_mem_resp = 1'b0;
    i_arb_mem_read = 1'b0;
    settle();
    chk("i_drop_rd", 128'(l2arb_mem_read), 128'd0);
    chk("i_drop_resp", 128'(i_arb_mem_resp), 128'd0);

    // Stray L2 resp while idle reaches nobody.
    l2arb_mem_resp = 1'b1;
    settle();
    chk("stray_iresp", 128'(i_arb_mem_resp), 128'd0);
    chk("stray_dresp", 128'(d_arb_mem_resp), 128'd0);
    cyc();
    l2arb_mem_resp = 1'b0;
    settle();
    chk_idle("stray_after");

    // dcache writeback followed by a dcache read after the idle gap.
    d_arb_mem_address = 16'h2000;
    d_arb_mem_wdata   = WDATA;
    d_arb_mem_write   = 1'b1;
    cyc();
    chk("w_wr",   128'(l2arb_mem_write),   128'd1);
    chk("w_rd",   128'(l2arb_mem_read),    128'd0);
    chk("w_addr", 128'(l2arb_mem_address), 128'h2000);
    chk("w_wd",   l2arb_mem_wdata,         WDATA);
    cyc(); cyc();
    l2arb_mem_resp = 1'b1;
    settle();
    chk("w_dresp", 128'(d_arb_mem_resp), 128'd1);
    cyc();
    l2arb_mem_resp    = 1'b0;
    d_arb_mem_write   = 1'b0;
    d_arb_mem_read    = 1'b1;
    d_arb_mem_address = 16'h3000;
    settle();
    chk("wr_gap_rd", 128'(l2arb_mem_read),  128'd0);
    chk("wr_gap_wr", 128'(l2arb_mem_write), 128'd0);
    cyc();
    chk("r_rd",   128'(l2arb_mem_read),    128'd1);
    chk("r_wr",   128'(l2arb_mem_write),   128'd0);
    chk("r_addr", 128'(l2arb_mem_address), 128'h3000);
    l2arb_mem_resp = 1'b1;
    settle();
    chk("r_dresp", 128'(d_arb_mem_resp), 128'd1);
    cyc();
    l2arb_mem_resp = 1'b0;
    d_arb_mem_read = 1'b0;
    settle();

    // Reset two cycles into a dcache transaction; late L2 resp is dropped.
    d_arb_mem_address = 16'h1230;
    d_arb_mem_read    = 1'b1;
    cyc();
    chk("mr_rd", 128'(l2arb_mem_read), 128'd1);
    cyc(); cyc();
    rst            = 1'b1;
    d_arb_mem_read = 1'b0;
    cyc();
    chk_idle("mr_rst");
    rst = 1'b0;
    cyc();
    l2arb_mem_resp = 1'b1;
    settle();
    chk("mr_late_iresp", 128'(i_arb_mem_resp), 128'd0);
    chk("mr_late_dresp", 128'(d_arb_mem_resp), 128'd0);
    cyc();
    l2arb_mem_resp = 1'b0;
    d_arb_mem_read = 1'b1;
    settle();
    chk("mr_idle_rd", 128'(l2arb_mem_read), 128'd0);
    cyc();
    chk("mr_rearb_rd",   128'(l2arb_mem_read),    128'd1);
    chk("mr_rearb_addr", 128'(l2arb_mem_address), 128'h1230);
    l2arb_mem_resp = 1'b1;
    cyc();
    l2arb_mem_resp = 1'b0;
    d_arb_mem_read = 1'b0;

    // Continuous contention from a clean reset: check grant order and idle gaps.
    rst            = 1'b1;
    i_arb_mem_read = 1'b1;
    d_arb_mem_read = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    for (int g = 0; g < 10; g++) begin
      chk($sformatf("ord%0d_rd", g), 128'(l2arb_mem_read), 128'd1);
      chk($sformatf("ord%0d_addr", g), 128'(l2arb_mem_address),
          exp_i[g] ? 128'h0040 : 128'h1230);
      l2arb_mem_resp = 1'b1;
      settle();
      chk($sformatf("ord%0d_iresp", g), 128'(i_arb_mem_resp), 128'(exp_i[g]));
      chk($sformatf("ord%0d_dresp", g), 128'(d_arb_mem_resp), 128'(!exp_i[g]));
      cyc();
      l2arb_mem_resp = 1'b0;
      settle();
      chk($sformatf("ord%0d_gap_rd", g), 128'(l2arb_mem_read), 128'd0);
      chk($sformatf("ord%0d_gap_resp", g), 128'(i_arb_mem_resp | d_arb_mem_resp), 128'd0);
      cyc();
    end

    // Finish the in-flight grant cleanly before leaving.
    l2arb_mem_resp = 1'b1;
    cyc();
    l2arb_mem_resp = 1'b0;
    i_arb_mem_read = 1'b0;
    d_arb_mem_read = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
